// File: rtl/bus_timer_if.sv
// Bridge-to-peripheral bus as seen by a memory-mapped responder.
// The Bridge drives address/strobe/data; the responder returns combinational read data.
interface bus_timer_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, we, wdata, input rdata);
    modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped prescaled timer with compare match (irq), overflow flag and auto-reload.
// Optional one-shot halting on match is built when TIMER_ONESHOT_EN is defined.
module bus_timer #(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] RST_PRESC = '0
) (
    input  logic        clk,
    input  logic        rst,
    bus_timer_if.slave  bus,
    output logic        irq
);
    typedef enum logic [1:0] {
        REG_COUNT = 2'b00,
        REG_PRESC = 2'b01,
        REG_CMP   = 2'b10,
        REG_CTRL  = 2'b11
    } reg_sel_e;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count, presc, cmp, pc;
    logic [CNT_W-1:0] count_next, ctrl_rd;
    logic             en, ar, oneshot, match, ovf;
    logic             wr_count, wr_presc, wr_cmp, wr_ctrl;
    logic             tick, tick_eff, hit, set_match, set_ovf;
    reg_sel_e         sel;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{bus.addr[31:4], bus.addr[1:0]};

    assign sel      = reg_sel_e'(bus.addr[3:2]);
    assign wr_count = bus.we && (sel == REG_COUNT);
    assign wr_presc = bus.we && (sel == REG_PRESC);
    assign wr_cmp   = bus.we && (sel == REG_CMP);
    assign wr_ctrl  = bus.we && (sel == REG_CTRL);

    // A CPU write to COUNT swallows a coincident tick entirely, flags included.
    assign tick      = en && (pc == presc);
    assign tick_eff  = tick && !wr_count;
    assign hit       = (count == cmp);
    assign set_match = tick_eff && hit;
    assign set_ovf   = tick_eff && !hit && (count == '1);

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (wr_count)
            count_next = bus.wdata;
        else if (tick)
            count_next = (hit && ar) ? '0 : count + ONE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            presc <= RST_PRESC;
            cmp   <= '1;
            pc    <= '0;
        end else begin
            count <= count_next;
            if (wr_presc) presc <= bus.wdata;
            if (wr_cmp)   cmp   <= bus.wdata;
            if (wr_count || wr_presc)
                pc <= '0;
            else if (en)
                pc <= tick ? '0 : pc + ONE;
        end
    end

    // Hardware set is scheduled after the W1C so a coincident set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en    <= 1'b0;
            ar    <= 1'b0;
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en <= bus.wdata[0];
                ar <= bus.wdata[1];
                if (bus.wdata[8]) match <= 1'b0;
                if (bus.wdata[9]) ovf   <= 1'b0;
            end
            if (set_match) match <= 1'b1;
            if (set_ovf)   ovf   <= 1'b1;
            if (set_match && oneshot) en <= 1'b0;
        end
    end

`ifdef TIMER_ONESHOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oneshot <= 1'b0;
        else if (wr_ctrl)
            oneshot <= bus.wdata[2];
    end
`else
    assign oneshot = 1'b0;
`endif

    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[0] = en;
        ctrl_rd[1] = ar;
        ctrl_rd[2] = oneshot;
        ctrl_rd[8] = match;
        ctrl_rd[9] = ovf;
    end

    always_comb begin
        bus.rdata = '0;
        unique case (sel)
            REG_COUNT: bus.rdata = count;
            REG_PRESC: bus.rdata = presc;
            REG_CMP:   bus.rdata = cmp;
            REG_CTRL:  bus.rdata = ctrl_rd;
        endcase
    end

    assign irq = match;
endmodule
